syscall_console: RTL and testbench

SYSCALL_CONSOLE -- requirements
Module: syscall_console

---
 rtl/syscall_console.sv | 96 +++++++++
 tb/tb_syscall_console.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/syscall_console.sv
// Syscall decoder and print-request buffer: queues print-int/print-string
// requests for a console consumer and drains them before halting on exit.
module syscall_console #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        syscall_control,
  input  logic [31:0] instruction,
  input  logic [31:0] v0,
  input  logic [31:0] a0,
  output logic        stall,
  output logic        halt,
  output logic        cons_valid,
  input  logic        cons_ready,
  output logic [31:0] cons_data,
  output logic        cons_tag,
  output logic        bad_code,
  output logic [15:0] syscall_count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, HALTED} state_t;
  typedef struct packed {
    logic        tag;
    logic [31:0] data;
  } entry_t;

  state_t          state;
  entry_t          mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;

  logic detect, is_print, is_exit, full, accept, push, pop;
  logic unused_bits;

  assign unused_bits = ^instruction[31:6];

  assign detect   = syscall_control && (instruction[5:0] == 6'h0C);
  assign is_print = (v0 == 32'd1) || (v0 == 32'd4);
  assign is_exit  = (v0 == 32'd10);
  // Full comes from the registered count so a same-cycle pop cannot lift the stall.
  assign full     = (count == CW'(FIFO_DEPTH));
  assign stall    = (state != IDLE) || (detect && is_print && full);
  assign accept   = detect && (state == IDLE) && !stall;
  assign push     = accept && is_print;

  assign cons_valid = (count != '0);
  assign pop        = cons_valid && cons_ready;
  assign cons_data  = cons_valid ? mem[rd_ptr].data : '0;
  assign cons_tag   = cons_valid ? mem[rd_ptr].tag  : 1'b0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{tag: (v0 == 32'd4), data: a0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      halt          <= 1'b0;
      bad_code      <= 1'b0;
      syscall_count <= '0;
    end else begin
      if (accept && syscall_count != 16'hFFFF) syscall_count <= syscall_count + 16'd1;
      if (accept && !is_print && !is_exit)     bad_code <= 1'b1;
      case (state)
        IDLE:    if (accept && is_exit) state <= DRAIN;
        DRAIN:   if (count == '0) begin
                   state <= HALTED;
                   halt  <= 1'b1;
                 end
        HALTED:  state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_syscall_console.sv
// Directed bench for syscall_console with a queue scoreboard of expected
// console entries checked as the consumer pops them.
module tb_syscall_console;

  logic        clk = 1'b0;
  logic        rst;
  logic        syscall_control;
  logic [31:0] instruction, v0, a0;
  logic        stall, halt, cons_valid, cons_ready, cons_tag, bad_code;
  logic [31:0] cons_data;
  logic [15:0] syscall_count;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [32:0] q[$];
  logic [15:0] exp_count;

  syscall_console #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .syscall_control(syscall_control),
    .instruction(instruction), .v0(v0), .a0(a0),
    .stall(stall), .halt(halt), .cons_valid(cons_valid), .cons_ready(cons_ready),
    .cons_data(cons_data), .cons_tag(cons_tag), .bad_code(bad_code),
    .syscall_count(syscall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds a syscall on the inputs until the DUT takes it; records expectations at accept.
  task automatic sys_issue(input logic [31:0] code, input logic [31:0] arg);
    bit accepted = 0;
    syscall_control = 1'b1;
    instruction     = 32'h0000_000C;
    v0              = code;
    a0              = arg;
    for (int i = 0; i < 64 && !accepted; i++) begin
      @(negedge clk);
      if (!stall) begin
        accepted = 1;
        if (code == 32'd1 || code == 32'd4) q.push_back({code == 32'd4, arg});
        if (exp_count != 16'hFFFF) exp_count++;
      end
      @(posedge clk);
      #1;
    end
    syscall_control = 1'b0;
    instruction     = '0;
    check("accept_timeout", 64'(accepted), 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 32 && cons_valid; i++) tick();
    check("drain_valid", 64'(cons_valid), 64'd0);
    check("drain_queue", 64'(q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && cons_valid === 1'b1 && cons_ready === 1'b1) begin
      if (q.size() == 0) check("pop_unexpected", 64'(q.size()), 64'd1);
      else check("pop_entry", {31'd0, cons_tag, cons_data}, {31'd0, q.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; syscall_control = 1'b0; instruction = '0; v0 = '0; a0 = '0;
    cons_ready = 1'b0; exp_count = '0;
    tick(); tick();
    check("rst_valid", 64'(cons_valid), 64'd0);
    check("rst_halt",  64'(halt), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_bad",   64'(bad_code), 64'd0);
    check("rst_count", 64'(syscall_count), 64'd0);
    check("rst_data",  64'(cons_data), 64'd0);
    rst = 1'b0;
    tick();

    // Single print-int with consumer ready
    cons_ready = 1'b1;
    sys_issue(32'd1, 32'd42);
    check("p1_valid", 64'(cons_valid), 64'd1);
    check("p1_data",  64'(cons_data), 64'd42);
    check("p1_tag",   64'(cons_tag), 64'd0);
    check("p1_count", 64'(syscall_count), 64'(exp_count));
    tick();
    check("p1_popped", 64'(cons_valid), 64'd0);

    // Non-syscall funct must be ignored
    syscall_control = 1'b1; instruction = 32'h0000_0020; v0 = 32'd1; a0 = 32'd5;
    @(negedge clk);
    check("nf_stall", 64'(stall), 64'd0);
    tick(); tick();
    check("nf_count", 64'(syscall_count), 64'(exp_count));
    check("nf_valid", 64'(cons_valid), 64'd0);
    syscall_control = 1'b0; instruction = '0;

    // Fill the FIFO, fifth request stalls until the consumer frees a slot
    cons_ready = 1'b0;
    for (int i = 1; i <= 4; i++) sys_issue(32'd1, 32'(i));
    syscall_control = 1'b1; instruction = 32'h0000_000C; v0 = 32'd1; a0 = 32'd5;
    @(negedge clk);
    check("full_stall0", 64'(stall), 64'd1);
    tick();
    @(negedge clk);
    check("full_stall1", 64'(stall), 64'd1);
    check("full_head",   64'(cons_data), 64'd1);
    tick();
    cons_ready = 1'b1;
    sys_issue(32'd1, 32'd5);
    check("full_count", 64'(syscall_count), 64'(exp_count));
    drain();

    // Unsupported code is sticky and pushes nothing
    sys_issue(32'd7, 32'd123);
    check("bad_set",   64'(bad_code), 64'd1);
    check("bad_nopush", 64'(cons_valid), 64'd0);
    sys_issue(32'd4, 32'd99);
    check("bad_sticky", 64'(bad_code), 64'd1);
    drain();

    // Exit drains queued strings before halting
    cons_ready = 1'b0;
    sys_issue(32'd4, 32'h1000);
    sys_issue(32'd4, 32'h2000);
    sys_issue(32'd10, 32'd0);
    check("exit_stall", 64'(stall), 64'd1);
    check("exit_halt0", 64'(halt), 64'd0);
    tick(); tick(); tick();
    check("exit_hold_halt", 64'(halt), 64'd0);
    check("exit_hold_valid", 64'(cons_valid), 64'd1);
    cons_ready = 1'b1;
    for (int i = 0; i < 32 && !halt; i++) tick();
    check("exit_halt1", 64'(halt), 64'd1);
    check("exit_queue", 64'(q.size()), 64'd0);
    syscall_control = 1'b1; instruction = 32'h0000_000C; v0 = 32'd1; a0 = 32'd8;
    tick(); tick(); tick();
    check("halted_count", 64'(syscall_count), 64'(exp_count));
    check("halted_valid", 64'(cons_valid), 64'd0);
    check("halted_stall", 64'(stall), 64'd1);
    syscall_control = 1'b0; instruction = '0;

    // Reset out of HALTED, then asynchronous reset in the middle of DRAIN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_count = '0;
    tick();
    cons_ready = 1'b0;
    for (int i = 0; i < 3; i++) sys_issue(32'd1, 32'(16 + i));
    sys_issue(32'd10, 32'd0);
    check("mid_drain_stall", 64'(stall), 64'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 64'(cons_valid), 64'd0);
    check("arst_halt",  64'(halt), 64'd0);
    check("arst_count", 64'(syscall_count), 64'd0);
    check("arst_stall", 64'(stall), 64'd0);
    q.delete();
    exp_count = '0;
    tick();
    rst = 1'b0;
    cons_ready = 1'b1;
    sys_issue(32'd1, 32'd77);
    check("post_valid", 64'(cons_valid), 64'd1);
    check("post_data",  64'(cons_data), 64'd77);
    check("post_count", 64'(syscall_count), 64'(exp_count));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
